// File: rtl/bus_mux_pipe_if.sv
// rtl/bus_mux_pipe_if.sv - valid/ready port bundle for the registered channel multiplexer
interface bus_mux_pipe_if #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_CH    = 9,
  parameter int SEL_SIZE  = 4,
  parameter int ERR_CNT_W = 8
);
  logic [NUM_CH*WORD_SIZE-1:0] data_in;
  logic [SEL_SIZE-1:0]         sel;
  logic                        in_valid;
  logic                        in_ready;
  logic [WORD_SIZE-1:0]        mux_out;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_err;
  logic                        sel_err;
  logic [ERR_CNT_W-1:0]        err_count;

  modport master (
    output data_in, sel, in_valid, out_ready,
    input  in_ready, mux_out, out_valid, out_err, sel_err, err_count
  );

  modport slave (
    input  data_in, sel, in_valid, out_ready,
    output in_ready, mux_out, out_valid, out_err, sel_err, err_count
  );
endinterface

// File: rtl/bus_mux_pipe.sv
// rtl/bus_mux_pipe.sv - N-channel word mux behind a two-entry (output + skid) elastic stage
// Optional BUS_MUX_HOLD_LAST_EN: out-of-range selects reuse the last in-range word instead of 0.
module bus_mux_pipe #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_CH    = 9,
  parameter int SEL_SIZE  = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  bus_mux_pipe_if.slave bus
);

  typedef enum logic [1:0] {S_EMPTY, S_HALF, S_FULL} state_t;

  state_t                 r_state;
  logic [WORD_SIZE-1:0]   r_out_word;
  logic                   r_out_err;
  logic [WORD_SIZE-1:0]   r_skid_word;
  logic                   r_skid_err;
  logic                   r_sel_err;
  logic [ERR_CNT_W-1:0]   r_err_count;

  logic                   w_in_range;
  logic                   w_accept;
  logic                   w_take;
  logic                   w_out_valid;
  logic [WORD_SIZE-1:0]   w_chan;
  logic [WORD_SIZE-1:0]   w_word;

  assign w_in_range  = (32'(bus.sel) < 32'(NUM_CH));
  assign w_out_valid = (r_state != S_EMPTY);
  // in_ready is a pure function of state and rst so out_ready never reaches upstream.
  assign bus.in_ready = !rst && (r_state != S_FULL);
  assign w_accept    = bus.in_valid && bus.in_ready;
  assign w_take      = w_out_valid && bus.out_ready;

  always_comb begin
    w_chan = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (32'(bus.sel) == k) w_chan = bus.data_in[k*WORD_SIZE +: WORD_SIZE];
    end
  end

`ifdef BUS_MUX_HOLD_LAST_EN
  logic [WORD_SIZE-1:0] r_last_good;

  always_ff @(posedge clk) begin
    if (rst) r_last_good <= '0;
    else if (w_accept && w_in_range) r_last_good <= w_chan;
  end

  assign w_word = w_in_range ? w_chan : r_last_good;
`else
  assign w_word = w_in_range ? w_chan : '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_out_word  <= '0;
      r_out_err   <= 1'b0;
      r_skid_word <= '0;
      r_skid_err  <= 1'b0;
      r_sel_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_sel_err <= w_accept && !w_in_range;
      if (w_accept && !w_in_range && (r_err_count != '1))
        r_err_count <= r_err_count + ERR_CNT_W'(1);

      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_out_word <= w_word;
            r_out_err  <= !w_in_range;
            r_state    <= S_HALF;
          end
        end
        S_HALF: begin
          if (w_accept && w_take) begin
            r_out_word <= w_word;
            r_out_err  <= !w_in_range;
          end else if (w_accept) begin
            r_skid_word <= w_word;
            r_skid_err  <= !w_in_range;
            r_state     <= S_FULL;
          end else if (w_take) begin
            r_state <= S_EMPTY;
          end
        end
        S_FULL: begin
          // The skid word moves up before anything new can enter, keeping order.
          if (w_take) begin
            r_out_word <= r_skid_word;
            r_out_err  <= r_skid_err;
            r_state    <= S_HALF;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign bus.mux_out   = r_out_word;
  assign bus.out_err   = r_out_err;
  assign bus.out_valid = w_out_valid;
  assign bus.sel_err   = r_sel_err;
  assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_bus_mux_pipe.sv
// tb/tb_bus_mux_pipe.sv - vector table, corner sequences and randomized queue-model check of bus_mux_pipe
module tb_bus_mux_pipe;
  localparam int W = 16;
  localparam int N = 9;
  localparam int S = 4;
  localparam int E = 8;
`ifdef BUS_MUX_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
  localparam logic [15:0] HOLD_W = 16'hBEEF;
`else
  localparam bit HOLD = 1'b0;
  localparam logic [15:0] HOLD_W = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_mux_pipe_if #(.WORD_SIZE(W), .NUM_CH(N), .SEL_SIZE(S), .ERR_CNT_W(E)) ifc ();
  bus_mux_pipe_if #(.WORD_SIZE(W), .NUM_CH(N), .SEL_SIZE(S), .ERR_CNT_W(2)) sifc ();

  assign sifc.data_in   = ifc.data_in;
  assign sifc.sel       = ifc.sel;
  assign sifc.in_valid  = ifc.in_valid;
  assign sifc.out_ready = ifc.out_ready;

  bus_mux_pipe #(.WORD_SIZE(W), .NUM_CH(N), .SEL_SIZE(S), .ERR_CNT_W(E)) dut (
    .clk(clk), .rst(rst), .bus(ifc));
  bus_mux_pipe #(.WORD_SIZE(W), .NUM_CH(N), .SEL_SIZE(S), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(sifc));

  typedef struct {
    logic [W-1:0] word;
    bit           err;
  } ent_t;

  typedef struct {
    bit           r;
    bit           iv;
    logic [S-1:0] s;
    logic [W-1:0] w;
    bit           ordy;
    bit           x_ov;
    logic [W-1:0] x_out;
    bit           x_oerr;
    bit           x_irdy;
    bit           x_selerr;
    int           x_cnt;
  } vec_t;

  ent_t         q[$];
  vec_t         tbl[$];
  logic [W-1:0] chan[N];
  int           m_cnt, m_cnt2;
  bit           m_selerr, m_rst;
  logic [W-1:0] m_last;
  int           n_tests = 0;
  int           n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit r, input bit iv, input logic [S-1:0] s, input logic [W-1:0] w,
                     input bit ordy, input bit x_ov, input logic [W-1:0] x_out, input bit x_oerr,
                     input bit x_irdy, input bit x_selerr, input int x_cnt);
    vec_t v;
    v = '{r, iv, s, w, ordy, x_ov, x_out, x_oerr, x_irdy, x_selerr, x_cnt};
    tbl.push_back(v);
  endtask

  // One clock: drive inputs, advance the FIFO model, then compare after the edge.
  task automatic step(input bit r, input bit iv, input logic [S-1:0] s, input logic [W-1:0] w,
                      input bit ordy);
    bit   acc, tk, inr;
    ent_t e;
    for (int k = 0; k < N; k++) chan[k] = W'($urandom);
    inr = (int'(s) < N);
    if (inr) chan[int'(s)] = w;
    for (int k = 0; k < N; k++) ifc.data_in[k*W +: W] = chan[k];
    rst = r;
    ifc.in_valid = iv;
    ifc.sel = s;
    ifc.out_ready = ordy;
    if (r) begin
      q.delete();
      m_cnt = 0;
      m_cnt2 = 0;
      m_selerr = 1'b0;
      m_last = '0;
    end else begin
      acc = iv && (q.size() < 2);
      tk = (q.size() > 0) && ordy;
      e.err = !inr;
      e.word = inr ? chan[int'(s)] : (HOLD ? m_last : '0);
      if (tk) void'(q.pop_front());
      if (acc) q.push_back(e);
      m_selerr = acc && !inr;
      if (m_selerr) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (acc && inr) m_last = chan[int'(s)];
    end
    m_rst = r;
    @(posedge clk);
    #1;
    chk("out_valid", 32'(ifc.out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(ifc.in_ready), 32'(!m_rst && (q.size() < 2)));
    if (q.size() > 0) begin
      chk("mux_out", 32'(ifc.mux_out), 32'(q[0].word));
      chk("out_err", 32'(ifc.out_err), 32'(q[0].err));
    end
    if (m_rst) begin
      chk("rst_mux_out", 32'(ifc.mux_out), 32'h0);
      chk("rst_out_err", 32'(ifc.out_err), 32'h0);
    end
    chk("sel_err", 32'(ifc.sel_err), 32'(m_selerr));
    chk("err_count", 32'(ifc.err_count), 32'(m_cnt));
    chk("sat_err_count", 32'(sifc.err_count), 32'(m_cnt2));
  endtask

  initial begin
    step(1'b1, 1'b1, 4'd0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0);

    for (int k = 0; k < N; k++)
      add(0, 1, S'(k), 16'h1000 + 16'(k), 1, 1, 16'h1000 + 16'(k), 0, 1, 0, 0);
    add(0, 0, 4'd0, 16'h0000, 1, 0, 16'h0000, 0, 1, 0, 0);
    add(0, 1, 4'd2, 16'hAAAA, 0, 1, 16'hAAAA, 0, 1, 0, 0);
    add(0, 1, 4'd5, 16'h5555, 0, 1, 16'hAAAA, 0, 0, 0, 0);
    add(0, 0, 4'd0, 16'h0000, 0, 1, 16'hAAAA, 0, 0, 0, 0);
    add(0, 0, 4'd0, 16'h0000, 1, 1, 16'h5555, 0, 1, 0, 0);
    add(0, 0, 4'd0, 16'h0000, 1, 0, 16'h0000, 0, 1, 0, 0);
    add(0, 1, 4'd1, 16'h0001, 0, 1, 16'h0001, 0, 1, 0, 0);
    add(0, 1, 4'd3, 16'h0003, 1, 1, 16'h0003, 0, 1, 0, 0);
    add(0, 0, 4'd0, 16'h0000, 1, 0, 16'h0000, 0, 1, 0, 0);
    add(0, 1, 4'd0, 16'hBEEF, 1, 1, 16'hBEEF, 0, 1, 0, 0);
    add(0, 1, 4'hC, 16'h0000, 1, 1, HOLD_W,   1, 1, 1, 1);
    add(0, 1, 4'hF, 16'h0000, 1, 1, HOLD_W,   1, 1, 1, 2);
    add(0, 0, 4'd0, 16'h0000, 1, 0, 16'h0000, 0, 1, 0, 2);
    add(0, 1, 4'd2, 16'h1111, 0, 1, 16'h1111, 0, 1, 0, 2);
    add(0, 1, 4'd4, 16'h2222, 0, 1, 16'h1111, 0, 0, 0, 2);
    add(1, 1, 4'd7, 16'h0707, 1, 0, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 4'd7, 16'h0707, 0, 1, 16'h0707, 0, 1, 0, 0);
    add(0, 0, 4'd0, 16'h0000, 1, 0, 16'h0000, 0, 1, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].iv, tbl[i].s, tbl[i].w, tbl[i].ordy);
      chk($sformatf("vec%0d_ov", i), 32'(ifc.out_valid), 32'(tbl[i].x_ov));
      if (tbl[i].x_ov) begin
        chk($sformatf("vec%0d_out", i), 32'(ifc.mux_out), 32'(tbl[i].x_out));
        chk($sformatf("vec%0d_oerr", i), 32'(ifc.out_err), 32'(tbl[i].x_oerr));
      end
      chk($sformatf("vec%0d_irdy", i), 32'(ifc.in_ready), 32'(tbl[i].x_irdy));
      chk($sformatf("vec%0d_selerr", i), 32'(ifc.sel_err), 32'(tbl[i].x_selerr));
      chk($sformatf("vec%0d_cnt", i), 32'(ifc.err_count), 32'(tbl[i].x_cnt));
    end

    // Narrow counter saturates at 3 while the wide one keeps counting.
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 4'hD, 16'h0, 1'b1);
      chk($sformatf("sat%0d_narrow", i), 32'(sifc.err_count), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      chk($sformatf("sat%0d_wide", i), 32'(ifc.err_count), 32'(i + 1));
    end

    for (int i = 0; i < 3000; i++) begin
      logic [S-1:0] s;
      s = ($urandom_range(0, 3) == 0) ? S'($urandom_range(N, 15)) : S'($urandom_range(0, N - 1));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, s, W'($urandom),
           $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
